unstriping: RTL and testbench

UNSTRIPING -- requirements
Module: unstriping

---
 rtl/unstriping.sv | 97 +++++++++
 tb/tb_unstriping.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/unstriping.sv
// Unstriping: merges two striped lanes back into one ordered word stream.
// Lane 0 carries the 1st, 3rd, ... words and lane 1 the 2nd, 4th, ... words.
// Each lane is buffered in a small FIFO, and the FIFOs are drained alternately.
// The selector only advances when the chosen FIFO has a word, so the original
// order is kept even when one lane runs ahead of the other.
module unstriping #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk_2f,
   input  logic             reset,
   input  logic [WIDTH-1:0] lane_0,
   input  logic             valid_0,
   input  logic [WIDTH-1:0] lane_1,
   input  logic             valid_1,
   output logic [WIDTH-1:0] data_out,
   output logic             valid_out,
   output logic             err_overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem_0 [DEPTH];
   logic [WIDTH-1:0] mem_1 [DEPTH];
   logic [AW-1:0]    wr_ptr_0, rd_ptr_0, wr_ptr_1, rd_ptr_1;
   logic [CW-1:0]    cnt_0, cnt_1;
   logic             sel;

   logic empty_0, empty_1, full_0, full_1;
   logic rd_0, rd_1, wr_0, wr_1, ovf;

   // Empty/full come from the registered counts, so a word written on an edge
   // cannot be read on that same edge. A full FIFO still accepts a write when
   // it is being read on the same edge.
   assign empty_0 = (cnt_0 == '0);
   assign empty_1 = (cnt_1 == '0);
   assign full_0  = (cnt_0 == FULL_CNT);
   assign full_1  = (cnt_1 == FULL_CNT);
   assign rd_0    = !sel && !empty_0;
   assign rd_1    =  sel && !empty_1;
   assign wr_0    = valid_0 && (!full_0 || rd_0);
   assign wr_1    = valid_1 && (!full_1 || rd_1);
   assign ovf     = (valid_0 && full_0 && !rd_0) || (valid_1 && full_1 && !rd_1);

   // Lane storage; never observable while its count is zero, so it has no reset.
   always_ff @(posedge clk_2f) begin
      if (wr_0) mem_0[wr_ptr_0] <= lane_0;
      if (wr_1) mem_1[wr_ptr_1] <= lane_1;
   end

   // FIFO pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk_2f or negedge reset) begin
      if (!reset) begin
         wr_ptr_0 <= '0;
         rd_ptr_0 <= '0;
         cnt_0    <= '0;
         wr_ptr_1 <= '0;
         rd_ptr_1 <= '0;
         cnt_1    <= '0;
      end else begin
         if (wr_0) wr_ptr_0 <= wr_ptr_0 + AW'(1);
         if (rd_0) rd_ptr_0 <= rd_ptr_0 + AW'(1);
         if (wr_1) wr_ptr_1 <= wr_ptr_1 + AW'(1);
         if (rd_1) rd_ptr_1 <= rd_ptr_1 + AW'(1);
         cnt_0 <= cnt_0 + CW'(wr_0) - CW'(rd_0);
         cnt_1 <= cnt_1 + CW'(wr_1) - CW'(rd_1);
      end
   end

   // Merge register: pop the selected lane when it has data, otherwise hold the
   // selector and emit an idle (zero) cycle; overflow is sticky until reset.
   always_ff @(posedge clk_2f or negedge reset) begin
      if (!reset) begin
         data_out     <= '0;
         valid_out    <= 1'b0;
         sel          <= 1'b0;
         err_overflow <= 1'b0;
      end else begin
         if (rd_0) begin
            data_out  <= mem_0[rd_ptr_0];
            valid_out <= 1'b1;
            sel       <= 1'b1;
         end else if (rd_1) begin
            data_out  <= mem_1[rd_ptr_1];
            valid_out <= 1'b1;
            sel       <= 1'b0;
         end else begin
            data_out  <= '0;
            valid_out <= 1'b0;
         end
         if (ovf) err_overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_unstriping.sv
// Directed bench for unstriping with a scoreboard of expected merged words.
module tb_unstriping;

   localparam int WIDTH = 32;
   localparam int DEPTH = 4;

   logic             clk_2f = 1'b0;
   logic             reset  = 1'b1;
   logic [WIDTH-1:0] lane_0 = '0;
   logic             valid_0 = 1'b0;
   logic [WIDTH-1:0] lane_1 = '0;
   logic             valid_1 = 1'b0;
   logic [WIDTH-1:0] data_out;
   logic             valid_out;
   logic             err_overflow;

   int errors = 0;
   int checks = 0;
   logic [WIDTH-1:0] exp_q [$];

   unstriping #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk_2f       (clk_2f),
      .reset        (reset),
      .lane_0       (lane_0),
      .valid_0      (valid_0),
      .lane_1       (lane_1),
      .valid_1      (valid_1),
      .data_out     (data_out),
      .valid_out    (valid_out),
      .err_overflow (err_overflow)
   );

   always #5 clk_2f = ~clk_2f;

   task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v0, input logic [WIDTH-1:0] d0,
                        input logic v1, input logic [WIDTH-1:0] d1);
      valid_0 = v0;
      lane_0  = d0;
      valid_1 = v1;
      lane_1  = d1;
   endtask

   // One clock edge, then sample 1 time unit later and score the output.
   task automatic step();
      logic [WIDTH-1:0] e;
      @(posedge clk_2f);
      #1;
      if (valid_out === 1'b1) begin
         chk("out_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("order", data_out, e);
         end
      end else begin
         chk("idle_zero", {data_out[WIDTH-1:1], data_out[0] | valid_out}, '0);
      end
   endtask

   // Asynchronous reset pulse between edges; outputs must clear without a clock.
   task automatic do_reset();
      drive(1'b0, '0, 1'b0, '0);
      #2;
      reset = 1'b0;
      #1;
      chk("rst_data", data_out, '0);
      chk("rst_valid", 32'(valid_out), 32'd0);
      chk("rst_err", 32'(err_overflow), 32'd0);
      exp_q.delete();
      #1;
      reset = 1'b1;
   endtask

   initial begin
      int k0, k1;
      // Power-on reset, observed before any clock edge
      #1 reset = 1'b0;
      #1;
      chk("por_data", data_out, '0);
      chk("por_valid", 32'(valid_out), 32'd0);
      chk("por_err", 32'(err_overflow), 32'd0);
      @(posedge clk_2f); @(posedge clk_2f);
      #1;
      chk("por_hold_valid", 32'(valid_out), 32'd0);
      reset = 1'b1;

      // Basic order
      drive(1'b1, 32'hA0000001, 1'b0, '0); exp_q.push_back(32'hA0000001);
      step(); chk("basic_v_e1", 32'(valid_out), 32'd0);
      drive(1'b0, '0, 1'b1, 32'hB0000002); exp_q.push_back(32'hB0000002);
      step(); chk("basic_v_e2", 32'(valid_out), 32'd1);
      drive(1'b0, '0, 1'b0, '0);
      step(); chk("basic_v_e3", 32'(valid_out), 32'd1);
      step(); chk("basic_v_e4", 32'(valid_out), 32'd0);

      // Lane 1 arrives before its preceding lane-0 word
      drive(1'b0, '0, 1'b1, 32'h11111111);
      step(); chk("early_v_e1", 32'(valid_out), 32'd0);
      drive(1'b0, '0, 1'b0, '0);
      step(); chk("early_v_e2", 32'(valid_out), 32'd0);
      drive(1'b1, 32'h22222222, 1'b0, '0);
      exp_q.push_back(32'h22222222); exp_q.push_back(32'h11111111);
      step(); chk("early_v_e3", 32'(valid_out), 32'd0);
      drive(1'b0, '0, 1'b0, '0);
      step(); chk("early_v_e4", 32'(valid_out), 32'd1);
      step(); chk("early_v_e5", 32'(valid_out), 32'd1);
      chk("early_drained", 32'(exp_q.size()), 32'd0);

      // Overflow: lane 0 stalls on sel=1 and fills; word 6 is dropped
      exp_q.push_back(32'h1);
      for (int i = 1; i <= 5; i++) begin
         drive(1'b1, WIDTH'(i), 1'b0, '0);
         step();
      end
      chk("ovf_not_yet", 32'(err_overflow), 32'd0);
      drive(1'b1, 32'h6, 1'b0, '0);
      step(); chk("ovf_set", 32'(err_overflow), 32'd1);
      for (int i = 1; i <= 4; i++) begin
         exp_q.push_back(32'hB0 + WIDTH'(i));
         exp_q.push_back(WIDTH'(i + 1));
         drive(1'b0, '0, 1'b1, 32'hB0 + WIDTH'(i));
         step();
      end
      drive(1'b0, '0, 1'b0, '0);
      for (int i = 0; i < 10; i++) step();
      chk("ovf_sticky", 32'(err_overflow), 32'd1);
      chk("ovf_drained", 32'(exp_q.size()), 32'd0);
      do_reset();

      // Full FIFO read/write: lane 0 filled, then alternating traffic, 20 words
      for (int i = 0; i < 10; i++) begin
         exp_q.push_back(32'h0A000000 + WIDTH'(i));
         exp_q.push_back(32'h0B000000 + WIDTH'(i));
      end
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 32'h0A000000 + WIDTH'(i), 1'b0, '0);
         step();
      end
      drive(1'b0, '0, 1'b1, 32'h0B000000); step();
      drive(1'b0, '0, 1'b1, 32'h0B000001); step();
      k0 = 5;
      k1 = 2;
      while (k0 < 10 || k1 < 10) begin
         if (k0 < 10) begin
            drive(1'b1, 32'h0A000000 + WIDTH'(k0), 1'b0, '0);
            k0++;
            step();
         end
         if (k1 < 10) begin
            drive(1'b0, '0, 1'b1, 32'h0B000000 + WIDTH'(k1));
            k1++;
            step();
         end
      end
      drive(1'b0, '0, 1'b0, '0);
      for (int i = 0; i < 16; i++) step();
      chk("full_rw_no_ovf", 32'(err_overflow), 32'd0);
      chk("full_rw_drained", 32'(exp_q.size()), 32'd0);
      do_reset();

      // Async reset mid-stream with three words buffered and sel=1
      exp_q.push_back(32'hC0000001);
      exp_q.push_back(32'hD0000001);
      exp_q.push_back(32'hC0000002);
      drive(1'b1, 32'hC0000001, 1'b1, 32'hD0000001); step();
      drive(1'b1, 32'hC0000002, 1'b0, '0);           step();
      drive(1'b1, 32'hC0000003, 1'b0, '0);           step();
      drive(1'b1, 32'hC0000004, 1'b1, 32'hD0000002); step();
      chk("mid_out_before", data_out, 32'hC0000002);
      chk("mid_q_before", 32'(exp_q.size()), 32'd0);
      do_reset();
      drive(1'b1, 32'hCAFE0000, 1'b0, '0); exp_q.push_back(32'hCAFE0000);
      step(); chk("cafe_v_e1", 32'(valid_out), 32'd0);
      drive(1'b0, '0, 1'b0, '0);
      step(); chk("cafe_v_e2", 32'(valid_out), 32'd1);
      for (int i = 0; i < 6; i++) step();
      chk("cafe_drained", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
